// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Imported by pipe_ctrl and its down counter.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MUL_BUSY,
        DRAIN,
        HALTED
    } ctrl_state_t;

    localparam int unsigned MUL_LATENCY_DEF = 4;
    localparam int unsigned CNT_W           = 4;

    // DRAIN runs cnt = 2, 1, 0 -> three bubble cycles before HALTED.
    localparam logic [CNT_W-1:0] DRAIN_LOAD = 4'd2;

endpackage

// File: rtl/pipe_ctrl_down_counter.sv
// Loadable down counter with zero flag.
// Shared by the MUL_BUSY and DRAIN occupancy counts.
module pipe_ctrl_down_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges mul freeze, branch flush,
// load-use stall and halt into pipeline register controls.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_inst,
    input  logic        id_load_use,
    input  logic        id_halt_req,
    input  logic        ex_valid_inst,
    input  logic        ex_is_mul,
    input  logic        ex_take_branch,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        if_id_flush,
    output logic        id_ex_enable,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic        mul_busy,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    localparam bit MUL_MULTI = (MUL_LATENCY > 1);
    localparam bit MUL_LONG  = (MUL_LATENCY >= 3);
    localparam logic [CNT_W-1:0] MUL_LOAD =
        MUL_LONG ? CNT_W'(MUL_LATENCY - 3) : '0;

    ctrl_state_t      ctrl_state;
    ctrl_state_t      next_state;
    logic             mul_done;
    logic             mul_done_set;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic mul_trig;
    logic ev_mul;
    logic ev_br;
    logic ev_lu;
    logic ev_halt;

    assign mul_trig = ex_valid_inst & ex_is_mul
                    & ~mul_done & MUL_MULTI;

    // One-hot RUN events, highest priority wins.
    assign ev_mul  = mul_trig;
    assign ev_br   = ex_take_branch & ~ev_mul;
    assign ev_lu   = id_load_use & ~ev_mul & ~ex_take_branch;
    assign ev_halt = id_halt_req & id_valid_inst
                   & ~ev_mul & ~ex_take_branch & ~id_load_use;

    pipe_ctrl_down_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_state <= RUN;
        end else begin
            ctrl_state <= next_state;
        end
    end

    always_comb begin
        next_state   = ctrl_state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        mul_done_set = 1'b0;
        unique case (ctrl_state)
            RUN: begin
                unique case (1'b1)
                    ev_mul: begin
                        if (MUL_LONG) begin
                            next_state   = MUL_BUSY;
                            cnt_load     = 1'b1;
                            cnt_load_val = MUL_LOAD;
                        end else begin
                            mul_done_set = 1'b1;
                        end
                    end
                    ev_halt: begin
                        next_state   = DRAIN;
                        cnt_load     = 1'b1;
                        cnt_load_val = DRAIN_LOAD;
                    end
                    default: ;
                endcase
            end
            MUL_BUSY: begin
                if (cnt_zero) begin
                    next_state   = RUN;
                    mul_done_set = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    next_state = HALTED;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HALTED: ;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        if (!rst) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else begin
            unique case (ctrl_state)
                RUN: begin
                    unique case (1'b1)
                        ev_mul: begin
                            pc_enable     = 1'b0;
                            if_id_enable  = 1'b0;
                            id_ex_enable  = 1'b0;
                            ex_mem_bubble = 1'b1;
                        end
                        ev_br: begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end
                        ev_lu: begin
                            pc_enable    = 1'b0;
                            if_id_enable = 1'b0;
                            id_ex_flush  = 1'b1;
                        end
                        ev_halt: begin
                            pc_enable    = 1'b0;
                            if_id_enable = 1'b0;
                        end
                        default: ;
                    endcase
                end
                MUL_BUSY: begin
                    pc_enable     = 1'b0;
                    if_id_enable  = 1'b0;
                    id_ex_enable  = 1'b0;
                    ex_mem_bubble = 1'b1;
                end
                DRAIN: begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_flush  = 1'b1;
                end
                HALTED: begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_enable = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The mul advances on its last cycle, re-arming the trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_done <= 1'b0;
        end else if (mul_done_set) begin
            mul_done <= 1'b1;
        end else if (id_ex_enable) begin
            mul_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_enable &&
                     (ctrl_state == RUN || ctrl_state == MUL_BUSY)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign mul_busy = (ctrl_state == MUL_BUSY);
    assign halted   = (ctrl_state == HALTED);

endmodule
